mem_byte_responder: RTL and testbench
=====================================

Name: mem_byte_responder

Overview:
- Memory-side responder for the byte-serial data-memory bus driven by the MEM stage. Each cycle the MEM stage presents one byte address, a write enable and a write byte.
- Serves the request from an internal byte RAM, or from a memory-mapped I/O window containing a UART TX FIFO, a status register and a halt register.
- Returns read bytes with a fixed two-edge pipeline latency, matching the MEM stage's load sequencer, which captures each byte two stages after issuing its address.

Parameters:
ADDR_WIDTH, 32, width of the byte address bus
RAM_DEPTH, 131072, number of bytes of RAM, mapped at 0x0 .. RAM_DEPTH-1
IO_BASE, 32'h30000, base address of the I/O window
FIFO_DEPTH, 8, TX FIFO entries (power of two)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
mem_addr_i  input  ADDR_WIDTH  byte address from the MEM stage
mem_we_i  input  1  1 = write this cycle, 0 = read
mem_write_byte_i  input  8  write data byte
mem_read_byte_o  output  8  read data byte (registered)
tx_data_o  output  8  head byte of the TX FIFO
tx_valid_o  output  1  TX FIFO not empty
tx_ready_i  input  1  UART consumer accepts tx_data_o this cycle
halt_o  output  1  sticky simulation-halt flag
overflow_o  output  1  sticky TX overflow flag

Behaviour:
- Reset is sampled on posedge clk. It forces:
  - mem_read_byte_o=0, halt_o=0, overflow_o=0
  - FIFO pointers/count=0, so tx_valid_o=0 and tx_data_o=0
  - pipeline address register=0
- Reset does not clear RAM contents.
- Reset asserted mid-operation discards any in-flight read and any un-transmitted FIFO bytes.

Address decode (on the full address):
- RAM: addr < RAM_DEPTH.
- TXD: addr == IO_BASE.
- STAT: addr == IO_BASE+4.
- Anything else is unmapped.

Writes (mem_we_i=1), committed at the same posedge:
- RAM: ram[addr] <= mem_write_byte_i.
- TXD: push the byte into the FIFO. If the FIFO is full and no pop occurs that cycle, drop the byte and set overflow_o=1.
- STAT: set halt_o=1. halt_o stays 1 until reset.
- Unmapped: ignored.

Reads (mem_we_i=0), two-stage pipeline:
- Edge n: addr_q <= mem_addr_i.
- Edge n+1: mem_read_byte_o <= decode(addr_q).
- Net effect: an address presented in the cycle before edge n is visible on mem_read_byte_o after edge n+1 and is sampled by the consumer at edge n+2. One read may issue per cycle, fully pipelined.
- Read data by region:
  - RAM: ram[addr_q].
  - TXD: 0x00.
  - STAT: {5'b0, overflow_o, fifo_empty, fifo_full}, snapshot at edge n+1.
  - Unmapped: 0x00.
- The idle bus (addr 0, we 0) issues a harmless read of ram[0]. No side effects.
- mem_read_byte_o holds its last value while the bus issues writes.

Read/write interaction:
- Same-edge write and stage-B read of the same RAM address: read-first. The output shows the old byte.
- Write at edge n, then read address presented before edge n+1: returns the new byte.

TX FIFO:
- Circular buffer with a log2(FIFO_DEPTH)+1-bit count.
- Pop on posedge when tx_valid_o && tx_ready_i. tx_data_o is the head entry, driven combinationally from storage.
- Push and pop in the same cycle:
  - FIFO full: both happen, count unchanged, overflow not set.
  - FIFO empty: push only. The pushed byte appears on tx_data_o next cycle.
- Pointers wrap modulo FIFO_DEPTH.
- tx_ready_i while empty has no effect.

Test Plan:
- Reset then idle: after rst, mem_read_byte_o=0x00, tx_valid_o=0, halt_o=0, overflow_o=0. Holding rst for 3 cycles keeps all of these.
- Store then load: write 0x11,0x22,0x33,0x44 to 0x100..0x103 on consecutive cycles, then present reads 0x100..0x103 back-to-back. mem_read_byte_o shows 0x11,0x22,0x33,0x44 on consecutive cycles, each 2 edges after its address.
- Read-first/back-to-back: ram[0x40]=0xAA. In one cycle write 0xBB to 0x40 while addr_q=0x40; output is 0xAA. The next read of 0x40 returns 0xBB.
- UART: with tx_ready_i=0, write 0x48 and 0x69 to 0x30000. tx_valid_o=1 with tx_data_o=0x48. Raise tx_ready_i for 2 cycles: bytes pop as 0x48 then 0x69, then tx_valid_o=0.
- Full/overflow: with tx_ready_i=0, push 9 bytes 0x01..0x09. The ninth byte is dropped, overflow_o=1, and a STAT read returns 0x05. With tx_ready_i=1 and FIFO full, push 0x0A: count stays 8, and the last byte popped is 0x0A.
- Halt/unmapped: write 0x00 to 0x30004 sets halt_o=1 on the next edge. Reads of 0x40000 and 0x30000 return 0x00. Asserting rst clears halt_o.

Source files
------------

// File: rtl/mem_byte_responder.sv
// Byte-serial data-memory responder: byte RAM plus a small MMIO window
// (UART TX FIFO, status, halt) with a fixed two-edge read latency.
module mem_byte_responder #(
    parameter int          ADDR_WIDTH = 32,
    parameter int          RAM_DEPTH  = 131072,
    parameter logic [31:0] IO_BASE    = 32'h30000,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic                  mem_we_i,
    input  logic [7:0]            mem_write_byte_i,
    output logic [7:0]            mem_read_byte_o,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  halt_o,
    output logic                  overflow_o
);

    localparam int RAW = $clog2(RAM_DEPTH);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [ADDR_WIDTH-1:0] RAM_TOP   = ADDR_WIDTH'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] TXD_ADDR  = ADDR_WIDTH'(IO_BASE);
    localparam logic [ADDR_WIDTH-1:0] STAT_ADDR = ADDR_WIDTH'(IO_BASE + 32'd4);
    localparam logic [CW-1:0]         FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_RAM,
        REG_TXD,
        REG_STAT,
        REG_NONE
    } region_t;

    function automatic region_t decode(input logic [ADDR_WIDTH-1:0] a);
        region_t r;
        r = REG_NONE;
        unique case (1'b1)
            (a < RAM_TOP):    r = REG_RAM;
            (a == TXD_ADDR):  r = REG_TXD;
            (a == STAT_ADDR): r = REG_STAT;
            default:          r = REG_NONE;
        endcase
        return r;
    endfunction

    logic [7:0] ram [RAM_DEPTH];
    logic [7:0] fifo_mem [FIFO_DEPTH];

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  rd_q;
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [CW-1:0]         count;

    region_t    wr_reg;
    region_t    rd_reg;
    logic       fifo_empty;
    logic       fifo_full;
    logic       pop;
    logic       push_req;
    logic       push;
    logic       drop;
    logic       ram_we;
    logic       stat_we;
    logic [7:0] rd_mux;

    assign wr_reg = decode(mem_addr_i);
    assign rd_reg = decode(addr_q);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);

    // A full FIFO still accepts a push when the head leaves the same cycle.
    assign pop      = !fifo_empty && tx_ready_i;
    assign push_req = mem_we_i && (wr_reg == REG_TXD);
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;
    assign ram_we   = mem_we_i && (wr_reg == REG_RAM);
    assign stat_we  = mem_we_i && (wr_reg == REG_STAT);

    assign tx_valid_o = !fifo_empty;
    assign tx_data_o  = fifo_empty ? 8'h00 : fifo_mem[head];

    always_comb begin
        rd_mux = 8'h00;
        unique case (rd_reg)
            REG_RAM:  rd_mux = ram[addr_q[RAW-1:0]];
            REG_STAT: rd_mux = {5'b0, overflow_o, fifo_empty, fifo_full};
            default:  rd_mux = 8'h00;
        endcase
    end

    // Storage arrays carry no reset so they map onto plain memories.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            ram[mem_addr_i[RAW-1:0]] <= mem_write_byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_mem[tail] <= mem_write_byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rd_q   <= 1'b0;
        end else begin
            addr_q <= mem_addr_i;
            rd_q   <= !mem_we_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_read_byte_o <= 8'h00;
        end else if (rd_q) begin
            mem_read_byte_o <= rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head <= head + PW'(pop);
            tail <= tail + PW'(push);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            halt_o     <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            if (stat_we) begin
                halt_o <= 1'b1;
            end
            if (drop) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_byte_responder.sv
// Scoreboard bench for mem_byte_responder: a queue/array reference model
// predicts every cycle's outputs, a monitor compares them after each edge.
module tb_mem_byte_responder;

    localparam int          AW     = 32;
    localparam int          DEPTH  = 131072;
    localparam logic [31:0] IOB    = 32'h30000;
    localparam logic [31:0] STATA  = 32'h30004;
    localparam int          FDEPTH = 8;

    logic          clk;
    logic          rst;
    logic [AW-1:0] mem_addr_i;
    logic          mem_we_i;
    logic [7:0]    mem_write_byte_i;
    logic [7:0]    mem_read_byte_o;
    logic [7:0]    tx_data_o;
    logic          tx_valid_o;
    logic          tx_ready_i;
    logic          halt_o;
    logic          overflow_o;

    mem_byte_responder #(
        .ADDR_WIDTH(AW),
        .RAM_DEPTH (DEPTH),
        .IO_BASE   (IOB),
        .FIFO_DEPTH(FDEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_addr_i      (mem_addr_i),
        .mem_we_i        (mem_we_i),
        .mem_write_byte_i(mem_write_byte_i),
        .mem_read_byte_o (mem_read_byte_o),
        .tx_data_o       (tx_data_o),
        .tx_valid_o      (tx_valid_o),
        .tx_ready_i      (tx_ready_i),
        .halt_o          (halt_o),
        .overflow_o      (overflow_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] rd;
        bit         rd_known;
        bit         tv;
        logic [7:0] td;
        bit         halt;
        bit         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    bit [7:0]    mram [int unsigned];
    bit [7:0]    fq[$];
    bit          m_halt;
    bit          m_ovf;
    bit          pend_v;
    logic [31:0] pend_a;
    logic [7:0]  exp_rd;
    bit          exp_known;

    task automatic model_read(input logic [31:0] a,
                              output logic [7:0] v, output bit known);
        v     = 8'h00;
        known = 1'b1;
        if (a < 32'(DEPTH)) begin
            known = mram.exists(a);
            v     = known ? mram[a] : 8'h00;
        end else if (a == STATA) begin
            v = {5'b0, m_ovf, fq.size() == 0, fq.size() == FDEPTH};
        end
    endtask

    task automatic cyc(input bit r, input logic [31:0] a, input bit we,
                       input logic [7:0] wd, input bit rdy);
        exp_t e;
        rst              = r;
        mem_addr_i       = a;
        mem_we_i         = we;
        mem_write_byte_i = wd;
        tx_ready_i       = rdy;
        if (r) begin
            fq.delete();
            m_halt    = 1'b0;
            m_ovf     = 1'b0;
            exp_rd    = 8'h00;
            exp_known = 1'b1;
            pend_v    = 1'b0;
        end else begin
            if (pend_v) model_read(pend_a, exp_rd, exp_known);
            if (fq.size() > 0 && rdy) void'(fq.pop_front());
            if (we) begin
                if (a < 32'(DEPTH)) mram[a] = wd;
                else if (a == IOB) begin
                    if (fq.size() < FDEPTH) fq.push_back(wd);
                    else m_ovf = 1'b1;
                end else if (a == STATA) m_halt = 1'b1;
            end
            pend_v = !we;
            pend_a = a;
        end
        e.rd       = exp_rd;
        e.rd_known = exp_known;
        e.tv       = fq.size() > 0;
        e.td       = (fq.size() > 0) ? fq[0] : 8'h00;
        e.halt     = m_halt;
        e.ovf      = m_ovf;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic chk(input string n, input logic [7:0] act,
                       input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %02h, expected %02h", n, $time, act, req);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.rd_known) chk("read_byte", mem_read_byte_o, e.rd);
                chk("tx_valid", {7'b0, tx_valid_o}, {7'b0, e.tv});
                chk("tx_data", tx_data_o, e.td);
                chk("halt", {7'b0, halt_o}, {7'b0, e.halt});
                chk("overflow", {7'b0, overflow_o}, {7'b0, e.ovf});
            end
        end
    end

    function automatic logic [31:0] rnd_addr();
        unique case ($urandom_range(0, 9))
            0, 1, 2, 3, 4: return 32'($urandom_range(0, 15));
            5:             return 32'(DEPTH - 1);
            6:             return 32'(DEPTH);
            7, 8:          return IOB;
            default: begin
                unique case ($urandom_range(0, 2))
                    0:       return STATA;
                    1:       return 32'h40000;
                    default: return IOB + 32'd1;
                endcase
            end
        endcase
    endfunction

    initial begin
        logic [31:0] a;
        rst = 1'b1;
        mem_addr_i = '0;
        mem_we_i = 1'b0;
        mem_write_byte_i = 8'h00;
        tx_ready_i = 1'b0;

        repeat (3) cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 1, 8'h5A, 0);
        cyc(0, 0, 0, 8'h00, 0);

        for (int i = 0; i < 4; i++) cyc(0, 32'h100 + i, 1, 8'(8'h11 * (i + 1)), 0);
        for (int i = 0; i < 4; i++) cyc(0, 32'h100 + i, 0, 8'h00, 0);
        repeat (2) cyc(0, 0, 0, 8'h00, 0);

        cyc(0, 32'h40, 1, 8'hAA, 0);
        cyc(0, 32'h40, 0, 8'h00, 0);
        cyc(0, 32'h40, 1, 8'hBB, 0);
        cyc(0, 32'h40, 0, 8'h00, 0);
        repeat (2) cyc(0, 0, 0, 8'h00, 0);

        cyc(0, IOB, 1, 8'h48, 0);
        cyc(0, IOB, 1, 8'h69, 0);
        cyc(0, 0, 0, 8'h00, 0);
        repeat (2) cyc(0, 0, 0, 8'h00, 1);
        cyc(0, 0, 0, 8'h00, 0);

        for (int i = 1; i <= 9; i++) cyc(0, IOB, 1, 8'(i), 0);
        cyc(0, STATA, 0, 8'h00, 0);
        repeat (2) cyc(0, 0, 0, 8'h00, 0);
        cyc(0, IOB, 1, 8'h0A, 1);
        repeat (9) cyc(0, 0, 0, 8'h00, 1);

        cyc(0, STATA, 1, 8'h00, 0);
        cyc(0, 32'h40000, 0, 8'h00, 0);
        cyc(0, IOB, 0, 8'h00, 0);
        repeat (2) cyc(0, 0, 0, 8'h00, 0);
        cyc(1, 0, 0, 8'h00, 0);
        cyc(0, 0, 0, 8'h00, 0);

        for (int i = 0; i < 3000; i++) begin
            a = rnd_addr();
            cyc($urandom_range(0, 99) == 0, a, 1'($urandom_range(0, 1)),
                8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
        end

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
